// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// a constant-width helper used to size the internal counters.
package rst_seq_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      RESET     = 3'd0,
      WAIT_LOCK = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      SW_HOLD   = 3'd4
   } state_e;

   // Ceiling log2; returns 0 for inputs of 0 or 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result = 0;
      int unsigned rem;
      rem = (value > 0) ? value - 1 : 0;
      while (rem != 0) begin
         result++;
         rem = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear. Used both as a
// reset release stage (Din tied high) and as a level synchronizer.
module rst_seq_sync2 (
   input  logic Clk,
   input  logic Rst_async,
   input  logic Din,
   output logic Dout
);

   logic meta_q;

   always_ff @(posedge Clk or negedge Rst_async) begin
      if (!Rst_async) begin
         meta_q <= 1'b0;
         Dout   <= 1'b0;
      end else begin
         meta_q <= Din;
         Dout   <= meta_q;
      end
   end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Chip reset sequencer: holds all domains until PLL lock, releases them in
// index order with fixed spacing, and re-asserts on lock loss or SW request.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int unsigned N_DOMAINS    = 4,
   parameter int unsigned STAGE_DLY    = 16,
   parameter int unsigned LOCK_TIMEOUT = 1024,
   parameter int unsigned SWRST_MIN    = 8
) (
   input  logic                 Clk,
   input  logic                 Rst_async,
   input  logic                 Pll_locked,
   input  logic                 Sw_rst_req,
   output logic [N_DOMAINS-1:0] Rst_n_out,
   output logic                 Seq_done,
   output logic                 Lock_err,
   output logic [STATE_W-1:0]   State
);

   localparam int unsigned CNT_W = clog2((STAGE_DLY > SWRST_MIN) ? STAGE_DLY : SWRST_MIN);
   localparam int unsigned TMO_W = clog2(LOCK_TIMEOUT);
   localparam int unsigned IDX_W = clog2(N_DOMAINS) + 1;

   localparam logic [CNT_W-1:0] CNT_STAGE = CNT_W'(STAGE_DLY - 1);
   localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(SWRST_MIN - 1);
   localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

   logic                 rst_int_n;
   logic                 lock_s;
   state_e               state_q, state_nxt;
   logic [CNT_W-1:0]     cnt_q, cnt_nxt;
   logic [TMO_W-1:0]     tmo_q, tmo_nxt;
   logic [IDX_W-1:0]     idx_q, idx_nxt;
   logic [N_DOMAINS-1:0] rst_n_q, rst_n_nxt, rel_mask;
   logic                 seq_done_q, seq_done_nxt;
   logic                 lock_err_q, lock_err_nxt;

   rst_seq_sync2 u_rst_sync (
      .Clk       (Clk),
      .Rst_async (Rst_async),
      .Din       (1'b1),
      .Dout      (rst_int_n)
   );

   rst_seq_sync2 u_lock_sync (
      .Clk       (Clk),
      .Rst_async (Rst_async),
      .Din       (Pll_locked),
      .Dout      (lock_s)
   );

   always_ff @(posedge Clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= RESET;
         cnt_q      <= '0;
         tmo_q      <= '0;
         idx_q      <= '0;
         rst_n_q    <= '0;
         seq_done_q <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         cnt_q      <= cnt_nxt;
         tmo_q      <= tmo_nxt;
         idx_q      <= idx_nxt;
         rst_n_q    <= rst_n_nxt;
         seq_done_q <= seq_done_nxt;
         lock_err_q <= lock_err_nxt;
      end
   end

   // Software request outranks lock loss in both RELEASE and RUN.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      tmo_nxt   = tmo_q;
      idx_nxt   = idx_q;
      case (state_q)
         RESET: begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
            tmo_nxt   = '0;
            idx_nxt   = '0;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = RELEASE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
               tmo_nxt   = '0;
            end else if (tmo_q != TMO_MAX) begin
               tmo_nxt = tmo_q + TMO_W'(1);
            end
         end
         RELEASE, RUN: begin
            if (Sw_rst_req) begin
               state_nxt = SW_HOLD;
               cnt_nxt   = '0;
            end else if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               tmo_nxt   = '0;
            end else if (state_q == RELEASE) begin
               if (cnt_q == CNT_STAGE) begin
                  cnt_nxt = '0;
                  idx_nxt = idx_q + IDX_W'(1);
                  if (idx_q == IDX_LAST) state_nxt = RUN;
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
         end
         SW_HOLD: begin
            if (cnt_q == CNT_HOLD) begin
               state_nxt = WAIT_LOCK;
               tmo_nxt   = '0;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         default: state_nxt = RESET;
      endcase
   end

   // Outputs are derived from the next state so they register alongside it.
   always_comb begin
      rel_mask = '0;
      for (int unsigned i = 0; i < N_DOMAINS; i++)
         rel_mask[i] = (state_q == RELEASE) && (cnt_q == CNT_STAGE) && (idx_q == IDX_W'(i));
      rst_n_nxt    = '0;
      seq_done_nxt = 1'b0;
      lock_err_nxt = lock_err_q;
      case (state_nxt)
         RELEASE: begin
            rst_n_nxt    = rst_n_q | rel_mask;
            lock_err_nxt = 1'b0;
         end
         RUN: begin
            rst_n_nxt    = '1;
            seq_done_nxt = 1'b1;
         end
         WAIT_LOCK: begin
            if (tmo_nxt == TMO_MAX) lock_err_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   assign Rst_n_out = rst_n_q;
   assign Seq_done  = seq_done_q;
   assign Lock_err  = lock_err_q;
   assign State     = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a timestamp-based reference model predicts
// every cycle's outputs; a monitor compares them on the falling clock edge.
module tb_rst_seq_ctrl;

   localparam int N  = 4;
   localparam int SD = 16;
   localparam int LT = 1024;
   localparam int SM = 8;
   localparam int OW = N + 5;

   logic         Clk;
   logic         Rst_async;
   logic         Pll_locked;
   logic         Sw_rst_req;
   logic [N-1:0] Rst_n_out;
   logic         Seq_done;
   logic         Lock_err;
   logic [2:0]   State;

   rst_seq_ctrl #(
      .N_DOMAINS    (N),
      .STAGE_DLY    (SD),
      .LOCK_TIMEOUT (LT),
      .SWRST_MIN    (SM)
   ) dut (
      .Clk        (Clk),
      .Rst_async  (Rst_async),
      .Pll_locked (Pll_locked),
      .Sw_rst_req (Sw_rst_req),
      .Rst_n_out  (Rst_n_out),
      .Seq_done   (Seq_done),
      .Lock_err   (Lock_err),
      .State      (State)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Expected observation per cycle: {Rst_n_out, Seq_done, Lock_err, State}.
   logic [OW-1:0] exp_q[$];

   // Reference model: what phase we are in and when it started.
   typedef enum int {M_RESET, M_WAIT, M_SEQ, M_HOLD} mode_t;
   mode_t       m_mode     = M_RESET;
   longint      now        = 0;
   longint      t0         = 0;
   int          rel_cnt    = 0;
   bit          m_lock_err = 1'b0;
   bit          lock_hist[$];
   bit          rst_seen   = 1'b0;

   always @(negedge Rst_async) rst_seen = 1'b1;

   always @(posedge Clk) begin
      bit           lock_s;
      int           released;
      logic [N-1:0] rmask;
      bit           sd;
      logic [2:0]   st;
      now++;
      if (!Rst_async || rst_seen) begin
         m_mode     = M_RESET;
         m_lock_err = 1'b0;
         rel_cnt    = 0;
         lock_hist.delete();
      end
      rst_seen = 1'b0;
      if (Rst_async) begin
         lock_s = (lock_hist.size() >= 2) ? lock_hist[lock_hist.size()-2] : 1'b0;
         lock_hist.push_back(Pll_locked);
         if (lock_hist.size() > 2) void'(lock_hist.pop_front());
         if (rel_cnt >= 2) begin
            case (m_mode)
               M_RESET: begin m_mode = M_WAIT; t0 = now; end
               M_WAIT: begin
                  if (lock_s) begin
                     m_mode = M_SEQ; t0 = now; m_lock_err = 1'b0;
                  end else if (now - t0 >= LT - 1) begin
                     m_lock_err = 1'b1;
                  end
               end
               M_SEQ: begin
                  if (Sw_rst_req) begin m_mode = M_HOLD; t0 = now; end
                  else if (!lock_s) begin m_mode = M_WAIT; t0 = now; end
               end
               M_HOLD: begin
                  if (now - t0 >= SM) begin m_mode = M_WAIT; t0 = now; end
               end
               default: m_mode = M_RESET;
            endcase
         end else begin
            rel_cnt++;
         end
      end
      rmask = '0;
      sd    = 1'b0;
      st    = 3'd0;
      case (m_mode)
         M_WAIT: st = 3'd1;
         M_HOLD: st = 3'd4;
         M_SEQ: begin
            released = int'((now - t0) / SD);
            if (released > N) released = N;
            for (int k = 0; k < N; k++) rmask[k] = (k < released);
            sd = (released == N);
            st = sd ? 3'd3 : 3'd2;
         end
         default: st = 3'd0;
      endcase
      exp_q.push_back({rmask, sd, m_lock_err, st});
   end

   always @(negedge Clk) begin
      logic [OW-1:0] act;
      logic [OW-1:0] want;
      act = {Rst_n_out, Seq_done, Lock_err, State};
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL cycle_out t=%0t: no expected entry queued, actual=%b", $time, act);
      end else begin
         want = exp_q.pop_front();
         if (act !== want) begin
            n_fail++;
            $display("FAIL cycle_out t=%0t: actual rst_n=%b done=%b err=%b state=%0d, required rst_n=%b done=%b err=%b state=%0d",
                     $time, act[OW-1:5], act[4], act[3], act[2:0],
                     want[OW-1:5], want[4], want[3], want[2:0]);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s t=%0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic wait_rst(input logic [N-1:0] val, input int budget, input string name);
      int k = 0;
      while (Rst_n_out !== val && k < budget) begin
         @(negedge Clk);
         k++;
      end
      n_checks++;
      if (Rst_n_out !== val) begin
         n_fail++;
         $display("FAIL %s: wait expired, actual rst_n=%b required=%b", name, Rst_n_out, val);
      end
   endtask

   // Call just after a falling edge: the pulse completes before the next rise.
   task automatic async_pulse(input string name);
      #1 Rst_async = 1'b0;
      #1;
      check({name, "_rst_n"}, 32'(Rst_n_out), 32'd0);
      check({name, "_done"},  32'(Seq_done),  32'd0);
      check({name, "_err"},   32'(Lock_err),  32'd0);
      check({name, "_state"}, 32'(State),     32'd0);
      #1 Rst_async = 1'b1;
   endtask

   initial begin
      int lock_low;
      Rst_async  = 1'b1;
      Pll_locked = 1'b1;
      Sw_rst_req = 1'b0;
      #1 Rst_async = 1'b0;
      #1;
      check("por_rst_n", 32'(Rst_n_out), 32'd0);
      check("por_done",  32'(Seq_done),  32'd0);
      check("por_err",   32'(Lock_err),  32'd0);
      check("por_state", 32'(State),     32'd0);

      // Power-up with lock already present
      cycles(5);
      #1 Rst_async = 1'b1;
      wait_rst('1, 100, "powerup_full_release");
      check("powerup_done", 32'(Seq_done), 32'd1);
      cycles(5);

      // Lock timeout, then recovery
      Pll_locked = 1'b0;
      async_pulse("tmo_async");
      cycles(1040);
      check("tmo_err",   32'(Lock_err),  32'd1);
      check("tmo_state", 32'(State),     32'd1);
      check("tmo_rst_n", 32'(Rst_n_out), 32'd0);
      Pll_locked = 1'b1;
      wait_rst('1, 100, "tmo_recover");
      check("tmo_err_cleared", 32'(Lock_err), 32'd0);
      cycles(3);

      // Lock loss mid-sequence
      async_pulse("loss_async");
      wait_rst(4'b0011, 200, "loss_reach_0011");
      Pll_locked = 1'b0;
      cycles(3);
      check("loss_rst_n", 32'(Rst_n_out), 32'd0);
      check("loss_state", 32'(State),     32'd1);
      cycles(1);
      Pll_locked = 1'b1;
      wait_rst('1, 120, "loss_rerelease");

      // Software reset in RUN with a second pulse during the hold
      cycles(4);
      Sw_rst_req = 1'b1;
      cycles(1);
      Sw_rst_req = 1'b0;
      check("sw_rst_n", 32'(Rst_n_out), 32'd0);
      check("sw_done",  32'(Seq_done),  32'd0);
      check("sw_state", 32'(State),     32'd4);
      cycles(2);
      Sw_rst_req = 1'b1;
      cycles(1);
      Sw_rst_req = 1'b0;
      wait_rst('1, 120, "sw_rerelease");

      // Sw request and lock loss reach the FSM on the same edge
      Sw_rst_req = 1'b1;
      cycles(1);
      Sw_rst_req = 1'b0;
      wait_rst(4'b0001, 120, "simul_reach_0001");
      Pll_locked = 1'b0;
      cycles(2);
      Sw_rst_req = 1'b1;
      cycles(1);
      Sw_rst_req = 1'b0;
      check("simul_state", 32'(State), 32'd4);
      cycles(3);
      Pll_locked = 1'b1;
      wait_rst('1, 150, "simul_rerelease");

      // Async reset while in RUN
      cycles(3);
      async_pulse("run_async");
      wait_rst('1, 100, "run_async_rerelease");

      // Randomized lock drops, software requests and async resets
      lock_low = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge Clk);
         Sw_rst_req = ($urandom_range(99) < 2);
         if (lock_low > 0) begin
            lock_low--;
            Pll_locked = (lock_low == 0);
         end else if ($urandom_range(199) == 0) begin
            lock_low   = int'($urandom_range(40, 2));
            Pll_locked = 1'b0;
         end
         if ($urandom_range(999) == 0) async_pulse("rand_async");
      end
      Sw_rst_req = 1'b0;
      Pll_locked = 1'b1;
      wait_rst('1, 200, "final_release");
      cycles(2);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
